// File: rtl/bist_response_analyzer_pkg.sv
// Shared BIST types and constants: analyser FSM states, default MISR constants
// and the capture count the controller produces (N passes x M words).
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPACT  = 2'd1,
    WAIT_FIN = 2'd2,
    RESULT   = 2'd3
  } state_t;

  localparam logic [7:0] DEF_POLY   = 8'h1D;
  localparam logic [7:0] DEF_SEED   = 8'h00;
  localparam logic [7:0] DEF_GOLDEN = 8'h00;

  localparam int unsigned N_PASSES     = 9;
  localparam int unsigned M_WORDS      = 9;
  localparam int unsigned EXP_CAPTURES = N_PASSES * M_WORDS;

  localparam int unsigned          CAP_W   = 8;
  localparam logic [CAP_W-1:0]     CAP_MAX = '1;

endpackage

// File: rtl/bist_response_analyzer_if.sv
// Controller-to-analyser control/response bus plus the analyser's result outputs.
interface bist_response_analyzer_if #(
  parameter int W = 8
);
  import bist_pkg::*;

  logic             RUNNING;
  logic             OUT;
  logic             FINISH;
  logic             BIST_END;
  logic [W-1:0]     CUT_RESP;

  logic [W-1:0]     SIGNATURE;
  logic [CAP_W-1:0] CAPTURES;
  logic             DONE;
  logic             PASS;
  logic             FAIL;
  logic             ERR;

  modport master (
    output RUNNING, OUT, FINISH, BIST_END, CUT_RESP,
    input  SIGNATURE, CAPTURES, DONE, PASS, FAIL, ERR
  );

  modport slave (
    input  RUNNING, OUT, FINISH, BIST_END, CUT_RESP,
    output SIGNATURE, CAPTURES, DONE, PASS, FAIL, ERR
  );
endinterface

// File: rtl/bist_response_analyzer_misr.sv
// W-bit multiple-input signature register. load restarts from SEED; enable folds
// in one data word (both together compact the first word straight into SEED).
module bist_misr #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = W'(bist_pkg::DEF_POLY),
  parameter logic [W-1:0]   SEED = W'(bist_pkg::DEF_SEED)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d, base;

  // NOTE: every variable of a combinational block gets a value before any branch, so no latch is inferred.
  always_comb begin
    base  = load ? SEED : sig_q;
    sig_d = base;
    if (enable) begin
      sig_d = {base[W-2:0], 1'b0} ^ (base[W-1] ? POLY : '0) ^ data;
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// BIST output-response analyser: compacts CUT responses into a MISR and grades the run.
// Optional macro BIST_ROA_STICKY_EN: FAIL survives later runs until reset and masks PASS.
module bist_response_analyzer #(
  parameter int           W            = 8,
  parameter logic [W-1:0] POLY         = W'(bist_pkg::DEF_POLY),
  parameter logic [W-1:0] SEED         = W'(bist_pkg::DEF_SEED),
  parameter logic [W-1:0] GOLDEN       = W'(bist_pkg::DEF_GOLDEN),
  parameter int unsigned  EXP_CAPTURES = bist_pkg::EXP_CAPTURES
) (
  input logic                     CLK,
  input logic                     RESET_N,
  bist_response_analyzer_if.slave bus
);
  import bist_pkg::*;

  localparam logic [CAP_W-1:0] EXP_CAP = CAP_W'(EXP_CAPTURES);

  state_t           state_q, state_d;
  logic [CAP_W-1:0] cap_q, cap_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             err_q, err_d;
  logic [W-1:0]     sig;
  logic             run_start, misr_en, conclude, abort, sig_match;

  // A run (re)starts from IDLE, or from WAIT_FIN when the controller restarts without finishing.
  assign run_start = bus.RUNNING && !bus.FINISH && (state_q == IDLE || state_q == WAIT_FIN);
  assign misr_en   = bus.RUNNING && bus.OUT && !bus.FINISH && (run_start || state_q == COMPACT);
  assign conclude  = (state_q == WAIT_FIN) && bus.FINISH && !bus.RUNNING;
  assign abort     = (state_q == COMPACT) && bus.FINISH;
  assign sig_match = (sig == GOLDEN) && (cap_q == EXP_CAP);

  bist_misr #(.W(W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .load   (run_start),
    .enable (misr_en),
    .data   (bus.CUT_RESP),
    .sig    (sig)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!bus.FINISH && bus.RUNNING) state_d = COMPACT;
      COMPACT:  if (bus.FINISH)                 state_d = IDLE;
                else if (!bus.RUNNING)          state_d = WAIT_FIN;
      WAIT_FIN: if (bus.FINISH)                 state_d = bus.RUNNING ? IDLE : RESULT;
                else if (bus.RUNNING)           state_d = COMPACT;
      RESULT:   if (!bus.BIST_END)              state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      IDLE, COMPACT: err_d = bus.FINISH;
      WAIT_FIN:      err_d = bus.RUNNING;
      default:       err_d = 1'b0;
    endcase

    cap_d = run_start ? '0 : cap_q;
    if (misr_en && cap_d != CAP_MAX) cap_d = cap_d + CAP_W'(1);

    done_d = done_q;
    pass_d = pass_q;
    fail_d = fail_q;
    if (run_start || abort) begin
      done_d = 1'b0;
      pass_d = 1'b0;
`ifndef BIST_ROA_STICKY_EN
      fail_d = 1'b0;
`endif
    end
    if (conclude) begin
      done_d = 1'b1;
`ifdef BIST_ROA_STICKY_EN
      fail_d = fail_q | ~sig_match;
      pass_d = sig_match & ~fail_d;
`else
      pass_d = sig_match;
      fail_d = ~sig_match;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cap_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      err_q  <= err_d;
    end
  end

  assign bus.SIGNATURE = sig;
  assign bus.CAPTURES  = cap_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.FAIL      = fail_q;
  assign bus.ERR       = err_q;

endmodule

// File: doc/bist_response_analyzer.md
Name: bist_response_analyzer

Overview:
Output-response analyser at the receiving end of the BIST controller's control interface. It consumes RUNNING/OUT/FINISH/BIST_END and the circuit-under-test response word, and compacts the responses into a MISR signature. On FINISH it checks the signature and the capture count against golden values and reports PASS/FAIL. It sits beside the controller and pattern generator in the BIST wrapper.

Parameters:
W, 8, response/MISR width (2..32)
POLY, 8'h1D, MISR feedback polynomial, W bits
SEED, 8'h00, MISR value loaded at run start
GOLDEN, 8'h00, expected final signature
EXP_CAPTURES, 81, expected number of captured words (9 passes x 9 words)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous, active-low reset
RUNNING  in  1  controller: pattern phase active
OUT  in  1  controller: current response is valid, capture it
FINISH  in  1  controller: one-cycle end-of-test pulse
BIST_END  in  1  controller: test complete, held until restart
CUT_RESP  in  W  CUT response word
SIGNATURE  out  W  current MISR contents
CAPTURES  out  8  number of captured words, saturates at 255
DONE  out  1  result valid
PASS  out  1  signature==GOLDEN and CAPTURES==EXP_CAPTURES
FAIL  out  1  DONE and not PASS
ERR  out  1  one-cycle protocol-violation pulse

Behaviour:
- Reset (async, RESET_N=0): state=IDLE; SIGNATURE=SEED; CAPTURES=0; DONE/PASS/FAIL/ERR=0. Asserting reset mid-run aborts immediately. Leaving reset occurs on the next clock edge with RESET_N=1.
- MISR step: sig_next = {sig[W-2:0],0} ^ (sig[W-1] ? POLY : 0) ^ CUT_RESP. All outputs are registered.
- States: IDLE, COMPACT, WAIT_FIN, RESULT.
- IDLE: RUNNING=1 -> COMPACT. In that same edge: SIGNATURE<=SEED, CAPTURES<=0, DONE/PASS/FAIL<=0. If OUT=1 on that cycle, the first word is compacted into SEED, so the capture starts at zero latency.
- COMPACT: each cycle with RUNNING=1 and OUT=1 -> MISR step, CAPTURES+1. With RUNNING=1 and OUT=0 -> hold (the controller's per-pass gap cycle). With RUNNING=0 -> WAIT_FIN.
- WAIT_FIN: FINISH=1 -> compare, then RESULT. On the next edge DONE=1 and PASS/FAIL are set. Latency from FINISH to DONE is 1 clock. RUNNING=1 here without FINISH -> ERR pulse, restart as from IDLE.
- RESULT: PASS/FAIL/DONE/SIGNATURE are held while BIST_END=1. When BIST_END falls -> IDLE, and the results are still held until the next RUNNING rise.
- Errors:
  - FINISH in IDLE or COMPACT -> ERR pulse. In COMPACT, also go to IDLE with DONE=0.
  - RUNNING=1 and FINISH=1 together -> ERR pulse, go to IDLE.
  - OUT=1 while RUNNING=0 is ignored.
- CAPTURES saturates at 255 with no wrap. A mismatch against EXP_CAPTURES gives FAIL even if the signature matches.

Optional Feature:
BIST_ROA_STICKY_EN:
- Defined: FAIL is sticky across runs and is only cleared by RESET_N. PASS is forced to 0 while the sticky FAIL is set.
- Undefined: PASS/FAIL are cleared at each run start (RUNNING rise from IDLE).

Decomposition:
- Package bist_pkg holds:
  - state typedef (IDLE, COMPACT, WAIT_FIN, RESULT)
  - default POLY/SEED/GOLDEN constants
  - EXP_CAPTURES = N*M with N=M=9, shared with the controller
- One natural sub-module: bist_misr, the W-bit MISR with load/enable inputs.

Test Plan:
1. Reset mid-COMPACT (RESET_N=0 after 3 captures) -> SIGNATURE=SEED, CAPTURES=0, DONE=0 immediately, without waiting for a clock.
2. W=8, POLY=1D, SEED=00, EXP_CAPTURES=2, GOLDEN=56. Drive RUNNING=1 for 3 cycles with OUT=1,1,0 and CUT_RESP=A5,01,xx; then RUNNING=0; then FINISH. Expect SIGNATURE A5 then 56, DONE=1 and PASS=1 one clock after FINISH.
3. Same as 2 with GOLDEN=57 -> FAIL=1, PASS=0. Same as 2 with EXP_CAPTURES=3 -> FAIL=1.
4. Full controller sequence (9x9 words), with GOLDEN taken from the model -> CAPTURES=81, PASS=1. Results stay held through BIST_END=1 and its fall, and clear at the next RUNNING rise (macro undefined).
5. FINISH pulse while IDLE -> ERR=1 for exactly one cycle, no state change. RUNNING and FINISH together in COMPACT -> ERR, state IDLE.
6. BIST_ROA_STICKY_EN defined: a failing run followed by a passing run -> FAIL stays 1 and PASS stays 0 until RESET_N is pulsed low.
